mix_columns_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/mix_columns_iter_if.sv | 25 ++
 rtl/mix_column_word.sv | 35 +++
 rtl/mix_columns_iter.sv | 117 +++++++++++
 tb/tb_mix_columns_iter.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers.
// Column layout: byte k at [127-8k -: 8], column c at [127-32c -: 32].
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mc_state_t;

    function automatic byte_t get_byte(state_t s, logic [3:0] k);
        return s[127-8*int'(k) -: 8];
    endfunction

    function automatic col_t get_col(state_t s, logic [1:0] c);
        return s[127-32*int'(c) -: 32];
    endfunction

    function automatic state_t set_col(state_t s, logic [1:0] c, col_t w);
        state_t r;
        r = s;
        r[127-32*int'(c) -: 32] = w;
        return r;
    endfunction

    function automatic byte_t xtime(byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t gf_mul2(byte_t x);
        return xtime(x);
    endfunction

    function automatic byte_t gf_mul3(byte_t x);
        return xtime(x) ^ x;
    endfunction

    function automatic byte_t gf_mul9(byte_t x);
        byte_t x8;
        x8 = xtime(xtime(xtime(x)));
        return x8 ^ x;
    endfunction

    function automatic byte_t gf_mul11(byte_t x);
        byte_t x2, x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ x;
    endfunction

    function automatic byte_t gf_mul13(byte_t x);
        byte_t x4, x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic byte_t gf_mul14(byte_t x);
        byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Valid/ready bus between row-shift, mix-columns and key-add stages.
// slave is the mix-columns side, master is the surrounding datapath.
interface mix_columns_iter_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_data;
    logic   in_inv;
    logic   in_bypass;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;

    modport slave (
        input  in_valid, in_data, in_inv, in_bypass, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_inv, in_bypass, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mix_column_word.sv
// One 32-bit column through MixColumns or InvMixColumns.
// Purely combinational; inv selects the inverse matrix.
module mix_column_word
    import aes_pkg::*;
(
    input  col_t a,
    input  logic inv,
    output col_t b
);

    byte_t a0, a1, a2, a3;
    col_t  fwd, bwd;

    assign a0 = a[31:24];
    assign a1 = a[23:16];
    assign a2 = a[15:8];
    assign a3 = a[7:0];

    assign fwd = {
        gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
        a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
        a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
        gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)
    };

    assign bwd = {
        gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
        gf_mul9(a0) ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
        gf_mul13(a0) ^ gf_mul9(a1) ^ gf_mul14(a2) ^ gf_mul11(a3),
        gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2) ^ gf_mul14(a3)
    };

    assign b = inv ? bwd : fwd;

endmodule

// File: rtl/mix_columns_iter.sv
// Column-serial MixColumns/InvMixColumns stage with final-round bypass.
// Mixes COLS_PER_CYCLE columns per clock in place, then holds the result.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst_n,
    mix_columns_iter_if.slave bus
);

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 ||
          COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_t st_q, st_n;
    state_t    data_q, data_n, calc;
    logic      inv_q, inv_n;
    logic      byp_q, byp_n;
    logic [1:0] cnt_q, cnt_n;
    logic [2:0] cnt_sum;
    logic      last;
    logic      rdy, vld;

    logic [1:0] idx     [COLS_PER_CYCLE];
    col_t       mix_in  [COLS_PER_CYCLE];
    col_t       mix_out [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        assign idx[i]    = cnt_q + 2'(i);
        assign mix_in[i] = get_col(data_q, idx[i]);
        mix_column_word u_mix (
            .a   (mix_in[i]),
            .inv (inv_q),
            .b   (mix_out[i])
        );
    end

    // Splice this clock's mixed columns back into the held state.
    always_comb begin
        calc = data_q;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            calc = set_col(calc, idx[i], mix_out[i]);
        end
    end

    // Bypass spends one clock in CALC with data held, matching the
    // single-clock latency of the full-width configuration.
    assign cnt_sum = {1'b0, cnt_q} + STEP;
    assign last    = byp_q | cnt_sum[2];

    // Next-state, next-data and state-decoded handshake outputs.
    always_comb begin
        st_n   = st_q;
        data_n = data_q;
        inv_n  = inv_q;
        byp_n  = byp_q;
        cnt_n  = cnt_q;
        rdy    = 1'b0;
        vld    = 1'b0;
        unique case (st_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.in_valid) begin
                    data_n = bus.in_data;
                    inv_n  = bus.in_inv;
                    byp_n  = bus.in_bypass;
                    cnt_n  = 2'd0;
                    st_n   = CALC;
                end
            end
            CALC: begin
                if (!byp_q) begin
                    data_n = calc;
                end
                cnt_n = last ? 2'd0 : cnt_sum[1:0];
                if (last) begin
                    st_n = DONE;
                end
            end
            DONE: begin
                vld = 1'b1;
                if (bus.out_ready) begin
                    st_n = IDLE;
                end
            end
            default: st_n = IDLE;
        endcase
    end

    // State, data and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            data_q <= '0;
            inv_q  <= 1'b0;
            byp_q  <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            st_q   <= st_n;
            data_q <= data_n;
            inv_q  <= inv_n;
            byp_q  <= byp_n;
            cnt_q  <= cnt_n;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter at COLS_PER_CYCLE 1, 2, 4.
// Reference model uses generic GF multiply and a coefficient table.
module tb_mix_columns_iter;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    mix_columns_iter_if ifc1 ();
    mix_columns_iter_if ifc2 ();
    mix_columns_iter_if ifc4 ();

    mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(ifc2.slave));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(ifc4.slave));

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic state_t ref_mix(state_t s, bit inv, bit byp);
        logic [7:0] cf [4];
        logic [7:0] acc;
        state_t o;
        if (byp) return s;
        if (inv) begin
            cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
        end else begin
            cf[0] = 8'd2; cf[1] = 8'd3; cf[2] = 8'd1; cf[3] = 8'd1;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(cf[(j - r + 4) % 4],
                                     s[127 - 8*(4*c + j) -: 8]);
                end
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic state_t rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic f_rdy(int sel);
        case (sel)
            1: return ifc1.in_ready;
            2: return ifc2.in_ready;
            default: return ifc4.in_ready;
        endcase
    endfunction

    function automatic logic f_val(int sel);
        case (sel)
            1: return ifc1.out_valid;
            2: return ifc2.out_valid;
            default: return ifc4.out_valid;
        endcase
    endfunction

    function automatic state_t f_data(int sel);
        case (sel)
            1: return ifc1.out_data;
            2: return ifc2.out_data;
            default: return ifc4.out_data;
        endcase
    endfunction

    task automatic drv_in(int sel, bit v, state_t d, bit inv, bit byp);
        case (sel)
            1: begin
                ifc1.in_valid = v; ifc1.in_data = d;
                ifc1.in_inv = inv; ifc1.in_bypass = byp;
            end
            2: begin
                ifc2.in_valid = v; ifc2.in_data = d;
                ifc2.in_inv = inv; ifc2.in_bypass = byp;
            end
            default: begin
                ifc4.in_valid = v; ifc4.in_data = d;
                ifc4.in_inv = inv; ifc4.in_bypass = byp;
            end
        endcase
    endtask

    task automatic drv_ordy(int sel, bit r);
        case (sel)
            1: ifc1.out_ready = r;
            2: ifc2.out_ready = r;
            default: ifc4.out_ready = r;
        endcase
    endtask

    task automatic do_txn(input int sel, input state_t d, input bit inv,
                          input bit byp, input bit ordy,
                          output state_t got, output int lat);
        int w = 0;
        lat = -1;
        got = '0;
        drv_ordy(sel, ordy);
        @(negedge clk);
        while (!f_rdy(sel) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!f_rdy(sel)) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout sel=%0d in_ready=0 required=1", sel);
            return;
        end
        drv_in(sel, 1'b1, d, inv, byp);
        @(posedge clk);
        #1;
        drv_in(sel, 1'b0, rnd128(), ~inv, ~byp);
        lat = 0;
        while (!f_val(sel) && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = f_data(sel);
        if (!f_val(sel)) begin
            n_vec++; n_err++;
            $display("FAIL valid_timeout sel=%0d out_valid=0 required=1", sel);
        end
    endtask

    task automatic chk_txn(string name, int sel, state_t d, bit inv,
                           bit byp, int exp_lat, state_t exp);
        state_t got;
        int lat;
        do_txn(sel, d, inv, byp, 1'b1, got, lat);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s_data sel=%0d got=%h required=%h",
                     name, sel, got, exp);
        end
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s_latency sel=%0d got=%0d required=%0d",
                     name, sel, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int s = 1; s <= 4; s = s * 2) begin
            n_vec++;
            if (f_rdy(s) !== 1'b1 || f_val(s) !== 1'b0 ||
                f_data(s) !== '0) begin
                n_err++;
                $display("FAIL reset sel=%0d rdy=%b val=%b data=%h required 1/0/0",
                         s, f_rdy(s), f_val(s), f_data(s));
            end
        end
    endtask

    task automatic test_forward();
        chk_txn("fwd_vec", 1,
                128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, 4,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    endtask

    task automatic test_inverse();
        state_t d, got;
        int lat;
        chk_txn("inv_vec", 1,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0, 4,
                128'hdb135345_f20a225c_01010101_c6c6c6c6);
        d = rnd128();
        d[127:64] = 64'hd4d4d4d5_2d26314c;
        do_txn(1, d, 1'b0, 1'b0, 1'b1, got, lat);
        n_vec++;
        if (got[127:64] !== 64'hd5d5d7d6_4d7ebdf8) begin
            n_err++;
            $display("FAIL fwd_cols got=%h required=d5d5d7d64d7ebdf8",
                     got[127:64]);
        end
        n_vec++;
        if (got !== ref_mix(d, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL fwd_model got=%h required=%h",
                     got, ref_mix(d, 1'b0, 1'b0));
        end
        chk_txn("inv_cols", 1, got, 1'b1, 1'b0, 4, d);
    endtask

    task automatic test_bypass();
        state_t d;
        d = rnd128();
        chk_txn("bypass1", 1, d, 1'b1, 1'b1, 1, d);
        d = rnd128();
        chk_txn("bypass2", 2, d, 1'b0, 1'b1, 1, d);
    endtask

    task automatic test_backpressure();
        state_t d, got;
        int lat;
        d = rnd128();
        do_txn(1, d, 1'b0, 1'b0, 1'b0, got, lat);
        n_vec++;
        if (got !== ref_mix(d, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL bp_data got=%h required=%h",
                     got, ref_mix(d, 1'b0, 1'b0));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv_in(1, 1'($urandom_range(0, 1)), rnd128(),
                   1'($urandom_range(0, 1)), 1'b0);
            n_vec++;
            if (f_data(1) !== got || f_val(1) !== 1'b1 ||
                f_rdy(1) !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d data=%h val=%b rdy=%b required %h/1/0",
                         i, f_data(1), f_val(1), f_rdy(1), got);
            end
        end
        @(negedge clk);
        drv_in(1, 1'b0, '0, 1'b0, 1'b0);
        drv_ordy(1, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if (f_val(1) !== 1'b0 || f_rdy(1) !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release val=%b rdy=%b required 0/1",
                     f_val(1), f_rdy(1));
        end
        d = rnd128();
        chk_txn("bp_next", 1, d, 1'b1, 1'b0, 4, ref_mix(d, 1'b1, 1'b0));
    endtask

    task automatic test_reset_mid();
        state_t d;
        drv_ordy(1, 1'b1);
        @(negedge clk);
        drv_in(1, 1'b1, rnd128(), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drv_in(1, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (f_val(1) !== 1'b0 || f_data(1) !== '0 || f_rdy(1) !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid val=%b data=%h rdy=%b required 0/0/1",
                     f_val(1), f_data(1), f_rdy(1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (f_val(1) !== 1'b0 || f_data(1) !== '0 || f_rdy(1) !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release val=%b data=%h rdy=%b required 0/0/1",
                     f_val(1), f_data(1), f_rdy(1));
        end
        d = rnd128();
        chk_txn("rst_next", 1, d, 1'b0, 1'b0, 4, ref_mix(d, 1'b0, 1'b0));
    endtask

    task automatic test_sweep();
        state_t d, f;
        for (int s = 2; s <= 4; s = s * 2) begin
            for (int k = 0; k < 5; k++) begin
                d = rnd128();
                f = ref_mix(d, 1'b0, 1'b0);
                chk_txn("sweep_fwd", s, d, 1'b0, 1'b0, 4 / s, f);
                chk_txn("sweep_inv", s, f, 1'b1, 1'b0, 4 / s, d);
            end
        end
    endtask

    task automatic test_back_to_back(int sel, bit byp, int exp_per);
        state_t q [$];
        state_t d, e;
        int last_acc = -1;
        int cyc;
        drv_ordy(sel, 1'b1);
        for (cyc = 0; cyc < 40 || (q.size() > 0 && cyc < 60); cyc++) begin
            @(negedge clk);
            if (f_val(sel) && q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (f_data(sel) !== e) begin
                    n_err++;
                    $display("FAIL b2b_data sel=%0d got=%h required=%h",
                             sel, f_data(sel), e);
                end
            end
            d = rnd128();
            if (cyc < 40 && f_rdy(sel)) begin
                if (last_acc >= 0) begin
                    n_vec++;
                    if (cyc - last_acc !== exp_per) begin
                        n_err++;
                        $display("FAIL b2b_period sel=%0d byp=%b got=%0d required=%0d",
                                 sel, byp, cyc - last_acc, exp_per);
                    end
                end
                last_acc = cyc;
                q.push_back(ref_mix(d, 1'b0, byp));
            end
            drv_in(sel, cyc < 40, d, 1'b0, byp);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain sel=%0d pending=%0d required=0",
                     sel, q.size());
        end
    endtask

    initial begin
        drv_in(1, 1'b0, '0, 1'b0, 1'b0);
        drv_in(2, 1'b0, '0, 1'b0, 1'b0);
        drv_in(4, 1'b0, '0, 1'b0, 1'b0);
        drv_ordy(1, 1'b0);
        drv_ordy(2, 1'b0);
        drv_ordy(4, 1'b0);
        test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_back_to_back(1, 1'b0, 6);
        test_back_to_back(2, 1'b0, 4);
        test_back_to_back(4, 1'b0, 3);
        test_back_to_back(1, 1'b1, 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
